fib_index: RTL

Inverse of the `fib` sequence generator. It accepts a 16-bit value and steps the same Fibonacci recurrence (current=1, previous=0, then current←current+previous) until it matches, passes, or exhausts the value. It reports whether the value is reachable, and the step count that produces it. It sits downstream of `fib`-driven logic as a checker/decoder, using valid/ready handshakes on both sides.

---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_step.sv | 23 ++
 rtl/fib_index.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci index decoder: FSM state encoding
// and the default value / step-count widths.
package fib_pkg;

    // Default value width and step-count width.
    localparam int FIB_W  = 16;
    localparam int FIB_CW = 4;

    // Decoder control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } fib_idx_state_e;

endpackage : fib_pkg

// File: rtl/fib_step.sv
// One step of the Fibonacci recurrence: sum of current and previous,
// computed one bit wider so the carry-out flags a W-bit overflow.
module fib_step
    import fib_pkg::*;
#(
    parameter int W = FIB_W
) (
    input  logic [W-1:0] cur_i,
    input  logic [W-1:0] prev_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] sum_wide;

    // Widened add; the top bit is the overflow flag, the rest is the next term.
    always_comb begin
        sum_wide = {1'b0, cur_i} + {1'b0, prev_i};
        sum_o    = sum_wide[W-1:0];
        ovf_o    = sum_wide[W];
    end

endmodule : fib_step

// File: rtl/fib_index.sv
// Fibonacci index decoder. Accepts a value, replays the Fibonacci
// recurrence from current=1/previous=0 and reports whether the value is
// reached and at which step the search stopped (hit, pass, step limit or
// W-bit overflow). Valid/ready handshakes on both input and output.
module fib_index
    import fib_pkg::*;
#(
    parameter int W  = FIB_W,
    parameter int CW = FIB_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_value,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_found,
    output logic [CW-1:0] out_count
);

    // Largest step index representable by the counter.
    localparam logic [CW-1:0] K_MAX = {CW{1'b1}};

    fib_idx_state_e state_q, state_d;

    logic [W-1:0]  cur_q,    cur_d;
    logic [W-1:0]  prev_q,   prev_d;
    logic [W-1:0]  target_q, target_d;
    logic [CW-1:0] k_q,      k_d;

    logic          out_valid_q, out_valid_d;
    logic          out_found_q, out_found_d;
    logic [CW-1:0] out_count_q, out_count_d;

    logic [W-1:0]  step_sum;
    logic          step_ovf;

    logic          hit;
    logic          passed;
    logic          exhausted;
    logic          search_end;

    fib_step #(
        .W (W)
    ) u_step (
        .cur_i  (cur_q),
        .prev_i (prev_q),
        .sum_o  (step_sum),
        .ovf_o  (step_ovf)
    );

    // Termination tests for the current step, in priority order: a match
    // wins over a pass, which wins over running out of steps or width.
    // Exhaustion is checked before stepping so a wrapped sum is never loaded.
    always_comb begin
        hit        = (cur_q == target_q);
        passed     = (cur_q > target_q);
        exhausted  = (k_q == K_MAX) || step_ovf;
        search_end = hit || passed || exhausted;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one accept, a search of k+1 cycles, then hold the
    // result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (search_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: the only combinational output is the input-side ready.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath next-state: latch the target on accept, advance the
    // recurrence during the search, capture the verdict when it ends.
    always_comb begin
        cur_d       = cur_q;
        prev_d      = prev_q;
        target_d    = target_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_found_d = out_found_q;
        out_count_d = out_count_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    target_d = in_value;
                    cur_d    = W'(1);
                    prev_d   = '0;
                    k_d      = '0;
                end
            end
            SEARCH: begin
                if (search_end) begin
                    out_valid_d = 1'b1;
                    out_found_d = hit;
                    out_count_d = k_q;
                end else begin
                    prev_d = cur_q;
                    cur_d  = step_sum;
                    k_d    = k_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers; reset clears everything so an aborted
    // search leaves no trace and no result is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q       <= '0;
            prev_q      <= '0;
            target_q    <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_found_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            target_q    <= target_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_found_q <= out_found_d;
            out_count_q <= out_count_d;
        end
    end

    // Result outputs come straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        out_found = out_found_q;
        out_count = out_count_q;
    end

endmodule : fib_index
